// File: rtl/vec_out_drain_ctrl.sv
// Output-side tile sequencer for the s8 vector packer: acknowledges tile requests
// and drains the packer's masked 32-bit word stream into a byte-addressed write port.
module vec_out_drain_ctrl #(
  parameter int VLEN  = 16,
  parameter int AW    = 32,
  parameter int DIM_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW-1:0]         cfg_base_addr,
  input  logic [DIM_W-1:0]      cfg_num_rows,
  input  logic [DIM_W-1:0]      cfg_num_cols,
  input  logic [DIM_W-1:0]      cfg_row_stride,
  output logic                  busy,
  output logic                  done,
  input  logic                  output_req,
  output logic                  req_ack,
  output logic [$clog2(VLEN):0] vec_valid_num_col,
  input  logic                  output_valid,
  output logic                  output_ready,
  input  logic [3:0]            output_mask,
  input  logic [31:0]           output_data,
  output logic                  wr_en,
  input  logic                  wr_ready,
  output logic [AW-1:0]         wr_addr,
  output logic [31:0]           wr_data,
  output logic [3:0]            wr_strb
);

  localparam int LOG_VLEN = $clog2(VLEN);
  localparam int VW       = LOG_VLEN + 1;
  localparam int WPR      = VLEN / 4;
  localparam int CNT_W    = $clog2(VLEN * WPR) + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_REQ = 2'd1,
    ACK      = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t             state_r;
  logic [AW-1:0]      base_r;
  logic [DIM_W-1:0]   rows_r;
  logic [DIM_W-1:0]   cols_r;
  logic [DIM_W-1:0]   stride_r;
  logic [DIM_W-1:0]   row_tile_r;
  logic [DIM_W-1:0]   col_tile_r;
  logic [CNT_W-1:0]   word_cnt_r;

  logic [VW-1:0]      tile_rows_s;
  logic [CNT_W-1:0]   tile_words_s;
  logic               last_word_s;
  logic               col_last_s;
  logic               row_last_s;
  logic               accept_s;
  logic [CNT_W-1:0]   r_s;
  logic [CNT_W-1:0]   w_s;
  logic [AW-1:0]      row_idx_s;

  // Extent of a tile along one dimension: the remainder past idx*VLEN, capped at VLEN.
  function automatic logic [VW-1:0] tile_len(input logic [DIM_W-1:0] total,
                                             input logic [DIM_W-1:0] idx);
    logic [DIM_W-1:0] rem;
    rem = total - (idx << LOG_VLEN);
    if (rem >= DIM_W'(VLEN)) begin
      tile_len = VW'(VLEN);
    end else begin
      tile_len = VW'(rem);
    end
  endfunction

  // Tile bookkeeping, handshakes and write-port addressing derived from current state.
  always_comb begin
    tile_rows_s  = tile_len(rows_r, row_tile_r);
    tile_words_s = CNT_W'(tile_rows_s) * CNT_W'(WPR);
    last_word_s  = (word_cnt_r == (tile_words_s - CNT_W'(1)));
    col_last_s   = ((cols_r - (col_tile_r << LOG_VLEN)) <= DIM_W'(VLEN));
    row_last_s   = ((rows_r - (row_tile_r << LOG_VLEN)) <= DIM_W'(VLEN));
    output_ready = (state_r == DRAIN) & (wr_ready | (output_mask == 4'b0000));
    wr_en        = (state_r == DRAIN) & output_valid & (output_mask != 4'b0000);
    accept_s     = (state_r == DRAIN) & output_valid & output_ready;
    r_s          = word_cnt_r / CNT_W'(WPR);
    w_s          = word_cnt_r % CNT_W'(WPR);
    row_idx_s    = (AW'(row_tile_r) << LOG_VLEN) + AW'(r_s);
    // Address arithmetic wraps modulo 2^AW by construction.
    wr_addr      = base_r + (row_idx_s * AW'(stride_r))
                 + (AW'(col_tile_r) << LOG_VLEN) + (AW'(w_s) << 2);
    wr_data      = output_data;
    wr_strb      = output_mask;
  end

  // Sequencer FSM: configuration latch, tile walk (columns inner), ack and done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r           <= IDLE;
      base_r            <= '0;
      rows_r            <= '0;
      cols_r            <= '0;
      stride_r          <= '0;
      row_tile_r        <= '0;
      col_tile_r        <= '0;
      word_cnt_r        <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      req_ack           <= 1'b0;
      vec_valid_num_col <= '0;
    end else begin
      done    <= 1'b0;
      req_ack <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if ((cfg_num_rows != '0) && (cfg_num_cols != '0)) begin
              base_r            <= cfg_base_addr;
              rows_r            <= cfg_num_rows;
              cols_r            <= cfg_num_cols;
              stride_r          <= cfg_row_stride;
              row_tile_r        <= '0;
              col_tile_r        <= '0;
              word_cnt_r        <= '0;
              busy              <= 1'b1;
              vec_valid_num_col <= tile_len(cfg_num_cols, '0);
              state_r           <= WAIT_REQ;
            end else begin
              done <= 1'b1;
            end
          end
        end
        WAIT_REQ: begin
          if (output_req) begin
            req_ack <= 1'b1;
            state_r <= ACK;
          end
        end
        ACK: begin
          word_cnt_r <= '0;
          state_r    <= DRAIN;
        end
        DRAIN: begin
          if (accept_s) begin
            if (last_word_s) begin
              word_cnt_r <= '0;
              if (col_last_s) begin
                col_tile_r        <= '0;
                vec_valid_num_col <= tile_len(cols_r, '0);
                if (row_last_s) begin
                  row_tile_r <= '0;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  state_r    <= IDLE;
                end else begin
                  row_tile_r <= row_tile_r + DIM_W'(1);
                  state_r    <= WAIT_REQ;
                end
              end else begin
                col_tile_r        <= col_tile_r + DIM_W'(1);
                vec_valid_num_col <= tile_len(cols_r, col_tile_r + DIM_W'(1));
                state_r           <= WAIT_REQ;
              end
            end else begin
              word_cnt_r <= word_cnt_r + CNT_W'(1);
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_out_drain_ctrl.sv
// Self-checking bench for vec_out_drain_ctrl: table of matrix shapes driven through a
// packer model, plus hand sequences for reset, degenerate start and mid-drain reset.
module tb_vec_out_drain_ctrl;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] cfg_base_addr;
  logic [15:0] cfg_num_rows, cfg_num_cols, cfg_row_stride;
  logic        busy, done, output_req, req_ack;
  logic [4:0]  vec_valid_num_col;
  logic        output_valid, output_ready;
  logic [3:0]  output_mask;
  logic [31:0] output_data;
  logic        wr_en, wr_ready;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vec_out_drain_ctrl #(.VLEN(16), .AW(32), .DIM_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base_addr(cfg_base_addr),
    .cfg_num_rows(cfg_num_rows), .cfg_num_cols(cfg_num_cols), .cfg_row_stride(cfg_row_stride),
    .busy(busy), .done(done), .output_req(output_req), .req_ack(req_ack),
    .vec_valid_num_col(vec_valid_num_col), .output_valid(output_valid),
    .output_ready(output_ready), .output_mask(output_mask), .output_data(output_data),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb)
  );

  typedef struct {
    int          rows;
    int          cols;
    int          stride;
    logic [31:0] base;
    int          wrmode;
    int          restart;
    int          acks;
    int          words;
    int          writes;
    logic [31:0] first;
    logic [31:0] last;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic int min16(input int x);
    return (x > 16) ? 16 : x;
  endfunction

  task automatic run_case(input int id, input vec_t v);
    int nct, cyc, ack_cnt, words, writes, tcnt, phase, done_cyc, last_acc;
    int rdy_err, addr_err, rt, ct, tc, wi, ri;
    logic [31:0] first_a, last_a, exp_a;
    logic [3:0]  bp, m;
    bit          finished;
    bp = 4'b1001;
    nct = (v.cols + 15) / 16;
    cyc = 0; ack_cnt = 0; words = 0; writes = 0; tcnt = 0; phase = 0;
    done_cyc = -1; last_acc = -100; rdy_err = 0; addr_err = 0; rt = 0; ct = 0;
    first_a = 32'h0; last_a = 32'h0; finished = 1'b0;
    @(posedge clk); #1;
    cfg_num_rows = 16'(v.rows); cfg_num_cols = 16'(v.cols);
    cfg_row_stride = 16'(v.stride); cfg_base_addr = v.base;
    start = 1'b1; output_req = 1'b1; output_valid = 1'b1;
    output_mask = 4'hF; output_data = 32'h0; wr_ready = 1'b1;
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      if (phase == 1) phase = 2;
      if (output_ready !== ((phase == 2) && (wr_ready || output_mask == 4'h0))) rdy_err++;
      if (wr_en !== ((phase == 2) && output_valid && output_mask != 4'h0)) rdy_err++;
      if (req_ack) begin
        if (ack_cnt == 0) begin
          check($sformatf("case%0d first_ack_cycle", id), cyc, 2);
          check($sformatf("case%0d busy_at_ack", id), busy, 1);
        end else begin
          check($sformatf("case%0d tile%0d_words", id, ack_cnt - 1), tcnt,
                min16(v.rows - ((ack_cnt - 1) / nct) * 16) * 4);
        end
        rt = ack_cnt / nct;
        ct = ack_cnt % nct;
        check($sformatf("case%0d tile%0d_valid_num", id, ack_cnt), vec_valid_num_col,
              min16(v.cols - ct * 16));
        ack_cnt++;
        tcnt = 0;
        phase = 1;
      end
      if (output_valid && output_ready) begin
        if (wr_en && wr_ready) begin
          ri = tcnt / 4;
          wi = tcnt % 4;
          exp_a = v.base + 32'((rt * 16 + ri) * v.stride + ct * 16 + 4 * wi);
          if (wr_addr !== exp_a || wr_data !== output_data || wr_strb !== output_mask) addr_err++;
          if (writes == 0) first_a = wr_addr;
          last_a = wr_addr;
          writes++;
        end
        words++;
        tcnt++;
        last_acc = cyc;
        if (tcnt == min16(v.rows - rt * 16) * 4) phase = 0;
      end
      if (done) begin
        done_cyc = cyc;
        check($sformatf("case%0d busy_at_done", id), busy, 0);
        finished = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (v.restart != 0 && cyc == 2) begin
        start = 1'b1;
        cfg_num_rows = 16'd16; cfg_num_cols = 16'd3; cfg_base_addr = 32'h0;
      end
      cyc++;
      output_data = $urandom;
      if (ack_cnt > 0) begin
        tc = min16(v.cols - ct * 16);
        wi = tcnt % 4;
        for (int i = 0; i < 4; i++) m[i] = ((4 * wi + i) < tc);
        output_mask = m;
      end
      wr_ready = (v.wrmode == 1) ? bp[cyc % 4] : 1'b1;
    end
    output_req = 1'b0; output_valid = 1'b0; start = 1'b0; wr_ready = 1'b1;
    check($sformatf("case%0d finished_in_budget", id), finished, 1);
    if (ack_cnt > 0)
      check($sformatf("case%0d last_tile_words", id), tcnt,
            min16(v.rows - ((ack_cnt - 1) / nct) * 16) * 4);
    check($sformatf("case%0d acks", id), ack_cnt, v.acks);
    check($sformatf("case%0d words", id), words, v.words);
    check($sformatf("case%0d writes", id), writes, v.writes);
    check($sformatf("case%0d first_addr", id), first_a, v.first);
    check($sformatf("case%0d last_addr", id), last_a, v.last);
    check($sformatf("case%0d done_latency", id), done_cyc, last_acc + 1);
    check($sformatf("case%0d ready_wren_errs", id), rdy_err, 0);
    check($sformatf("case%0d addr_data_errs", id), addr_err, 0);
  endtask

  initial begin
    int acc, errs;
    rst = 1'b1; start = 1'b0; cfg_base_addr = 32'h0; cfg_num_rows = 16'h0;
    cfg_num_cols = 16'h0; cfg_row_stride = 16'h0; output_req = 1'b1;
    output_valid = 1'b1; output_mask = 4'hF; output_data = 32'h0; wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset req_ack", req_ack, 0);
    check("reset wr_en", wr_en, 0);
    check("reset output_ready", output_ready, 0);
    check("reset valid_num", vec_valid_num_col, 0);
    @(posedge clk); #1;
    rst = 1'b0; output_req = 1'b0; output_valid = 1'b0;

    //          rows cols stride base          bp rs acks words writes first         last
    tbl[0] = '{16, 16, 16,  32'h0000_1000, 0, 0, 1,   64,  64, 32'h0000_1000, 32'h0000_10FC};
    tbl[1] = '{20, 20, 32,  32'h0000_2000, 0, 0, 4,  160, 100, 32'h0000_2000, 32'h0000_2270};
    tbl[2] = '{1,  7,  64,  32'h0000_3000, 0, 0, 1,    4,   2, 32'h0000_3000, 32'h0000_3004};
    tbl[3] = '{16, 8,  8,   32'h0000_4000, 1, 0, 1,   64,  32, 32'h0000_4000, 32'h0000_407C};
    tbl[4] = '{2,  4,  16,  32'hFFFF_FFF0, 0, 0, 1,    8,   2, 32'hFFFF_FFF0, 32'h0000_0000};
    tbl[5] = '{33, 17, 32,  32'h0000_0000, 0, 0, 6,  264, 165, 32'h0000_0000, 32'h0000_0410};
    tbl[6] = '{1,  16, 16,  32'h0000_5000, 0, 1, 1,    4,   4, 32'h0000_5000, 32'h0000_500C};
    for (int k = 0; k < 7; k++) run_case(k, tbl[k]);

    // Degenerate shapes: done pulses next cycle, busy never rises.
    @(posedge clk); #1;
    cfg_num_rows = 16'd0; cfg_num_cols = 16'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("m0 done", done, 1);
    check("m0 busy", busy, 0);
    @(negedge clk);
    check("m0 done_clears", done, 0);
    @(posedge clk); #1;
    cfg_num_rows = 16'd5; cfg_num_cols = 16'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("n0 done", done, 1);
    check("n0 busy", busy, 0);

    // Reset overrides a start in the same cycle.
    @(posedge clk); #1;
    cfg_num_rows = 16'd16; cfg_num_cols = 16'd16; rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start busy", busy, 0);

    // Reset in the middle of a drain.
    @(posedge clk); #1;
    cfg_num_rows = 16'd16; cfg_num_cols = 16'd16; cfg_row_stride = 16'd16;
    cfg_base_addr = 32'h6000; start = 1'b1; output_req = 1'b1;
    output_valid = 1'b1; output_mask = 4'hF; wr_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 40 && acc < 10; i++) begin
      @(negedge clk);
      if (output_valid && output_ready) acc++;
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("rst_mid accepted_before_reset", acc, 10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid busy", busy, 0);
    check("rst_mid req_ack", req_ack, 0);
    check("rst_mid wr_en", wr_en, 0);
    check("rst_mid output_ready", output_ready, 0);
    check("rst_mid valid_num", vec_valid_num_col, 0);
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || req_ack || busy || output_ready) errs++;
    end
    check("rst_mid no_activity_after", errs, 0);
    output_req = 1'b0; output_valid = 1'b0;
    run_case(7, tbl[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
